// File: rtl/prime_stream.sv
// prime_stream: request sequencer and output FIFO for a primegen instance.
//
// The block drives primegen's go input one request at a time. Each completed
// result is pushed into a small first-word-fall-through FIFO, and a consumer
// drains that FIFO over a valid/ready stream. Requests stop permanently, until
// rst, when the generator flags an error or when its output fails to increase
// (arithmetic wrap-around).
//
// Ports:
//   clk, rst              clock; synchronous active-high reset (shared with primegen)
//   en                    keep requesting primes while high and the FIFO has room
//   pg_go                 registered one-cycle request pulse to primegen
//   pg_ready, pg_error    primegen handshake and error status
//   pg_res                primegen result
//   out_valid/out_ready   output stream handshake (out_valid = FIFO not empty)
//   out_data              FIFO head entry
//   err                   sticky fault flag
//   prime_cnt             primes pushed since reset, modulo 2^WIDTH
module prime_stream #(
  parameter int WIDTH_LOG = 4,
  parameter int DEPTH_LOG = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  output logic                      pg_go,
  input  logic                      pg_ready,
  input  logic                      pg_error,
  input  logic [(1<<WIDTH_LOG)-1:0] pg_res,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [(1<<WIDTH_LOG)-1:0] out_data,
  output logic                      err,
  output logic [(1<<WIDTH_LOG)-1:0] prime_cnt
);

  localparam int WIDTH = 1 << WIDTH_LOG;
  localparam int DEPTH = 1 << DEPTH_LOG;

  typedef logic [WIDTH-1:0]     word_t;
  typedef logic [DEPTH_LOG-1:0] ptr_t;
  typedef logic [DEPTH_LOG:0]   cnt_t;

  typedef enum logic [2:0] {
    IDLE,
    GO,
    WAIT_DROP,
    WAIT_RDY,
    HALT
  } state_t;

  state_t state_q, state_d;
  logic   pg_go_q, pg_go_d;
  logic   err_q, err_d;
  word_t  last_q, last_d;
  word_t  prime_cnt_q, prime_cnt_d;
  ptr_t   wr_ptr_q, wr_ptr_d;
  ptr_t   rd_ptr_q, rd_ptr_d;
  cnt_t   count_q, count_d;
  word_t  mem_q [DEPTH];

  logic push;
  logic pop;

  // Sequencer. Only one request is ever in flight, and a request is only
  // issued while the FIFO has a free slot, so a push can never overflow.
  always_comb begin
    state_d     = state_q;
    err_d       = err_q;
    last_d      = last_q;
    prime_cnt_d = prime_cnt_q;
    push        = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && !err_q && (count_q < cnt_t'(DEPTH))) begin
          state_d = GO;
        end
      end
      GO: begin
        state_d = WAIT_DROP;
      end
      WAIT_DROP: begin
        // The ready seen before the request is stale; wait for primegen to
        // acknowledge by dropping it before looking for the new result.
        if (!pg_ready) begin
          state_d = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (pg_ready) begin
          // Primes must strictly increase; anything else means the generator
          // ran past the top of its range and wrapped.
          if (pg_error || (pg_res <= last_q)) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            push        = 1'b1;
            last_d      = pg_res;
            prime_cnt_d = prime_cnt_q + word_t'(1);
            state_d     = IDLE;
          end
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Registered so that pg_go is high exactly while the FSM sits in GO.
    pg_go_d = (state_d == GO);
  end

  // FIFO pointer and occupancy bookkeeping.
  always_comb begin
    pop      = (count_q != cnt_t'(0)) && out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
    if (push && !pop) begin
      count_d = count_q + cnt_t'(1);
    end else if (pop && !push) begin
      count_d = count_q - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pg_go_q     <= 1'b0;
      err_q       <= 1'b0;
      last_q      <= word_t'(1);
      prime_cnt_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pg_go_q     <= pg_go_d;
      err_q       <= err_d;
      last_q      <= last_d;
      prime_cnt_q <= prime_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage is not reset: entries are only visible through out_valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= pg_res;
    end
  end

  assign pg_go     = pg_go_q;
  assign err       = err_q;
  assign prime_cnt = prime_cnt_q;
  assign out_valid = (count_q != cnt_t'(0));
  assign out_data  = mem_q[rd_ptr_q];

endmodule
